// File: rtl/riscv_pkg.sv
// Shared types for the register-watch checker.
//   chk_state_e : checker FSM states
//   chk_entry_t : one expectation-table entry {flag, reg_addr, exp}
//   ZERO_REG    : architectural x0, hard-wired to zero
package riscv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCheck,
    StPass,
    StFail
  } chk_state_e;

  // "reg" is a keyword, so the register field is reg_addr.
  typedef struct packed {
    logic [7:0]  flag;
    logic [4:0]  reg_addr;
    logic [31:0] exp;
  } chk_entry_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the 32x32 architectural register file, built from snooped write-backs.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears every entry)
//   we_i/waddr_i/wdata_i  single write port; writes to x0 are dropped
//   raddr_a_i/rdata_a_o   asynchronous read port A (returns registered contents)
//   raddr_b_i/rdata_b_o   asynchronous read port B (returns registered contents)
module shadow_regfile
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != ZERO_REG)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-write value when a write lands in the same cycle.
  assign rdata_a_o = (raddr_a_i == ZERO_REG) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == ZERO_REG) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/reg_watch_checker.sv
// Self-checking monitor for a RISC-V core: snoops register write-backs into a shadow file,
// waits for the test-progress flag register to reach each table entry's flag value, then
// compares the named register against the expected value.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wb_we/wb_addr/wb_data    snooped register-file write-back
//   cfg_we/cfg_idx/cfg_flag/cfg_reg/cfg_exp  expectation-table write (only when not running)
//   num_checks, start        active entry count (latched on start), run start pulse
//   busy, done, pass, fail, timeout          run status
//   fail_idx, fail_got       index and shadow value of the first failure
//   checks_passed, run_cycles  matched-entry count, saturating cycles since start
module reg_watch_checker
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_CHECKS     = 16,
  parameter int unsigned FLAG_REG       = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STOP_ON_FAIL   = 1,
  localparam int unsigned IW            = $clog2(NUM_CHECKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [7:0]    cfg_flag,
  input  logic [4:0]    cfg_reg,
  input  logic [31:0]   cfg_exp,
  input  logic [IW:0]   num_checks,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [IW-1:0] fail_idx,
  output logic [31:0]   fail_got,
  output logic [IW:0]   checks_passed,
  output logic [31:0]   run_cycles
);

  localparam logic [IW-1:0] IdxOne      = IW'(1);
  localparam logic [IW:0]   CntOne      = (IW + 1)'(1);
  localparam logic [31:0]   TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    FlagAddr    = 5'(FLAG_REG);

  chk_state_e state_q, state_d;
  chk_entry_t table_q [NUM_CHECKS];

  logic [IW:0]   n_q, n_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   cp_q, cp_d;
  logic [IW-1:0] fail_idx_q, fail_idx_d;
  logic [31:0]   fail_got_q, fail_got_d;
  logic          fail_q, fail_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   run_q, run_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [31:0] flag_val;
  logic [31:0] chk_val;
  chk_entry_t  cur_entry;
  chk_entry_t  next_entry;
  logic        cfg_ok;
  logic        flag_hit;
  logic        is_last;
  logic        mismatch;
  logic        any_fail;

  shadow_regfile u_shadow (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (FlagAddr),
    .rdata_a_o (flag_val),
    .raddr_b_i (cur_entry.reg_addr),
    .rdata_b_o (chk_val)
  );

  assign cur_entry  = table_q[idx_q];
  assign next_entry = table_q[idx_q + IdxOne];
  assign cfg_ok     = cfg_we && (state_q inside {StIdle, StPass, StFail});
  assign flag_hit   = (flag_val == {24'b0, cur_entry.flag});
  assign is_last    = ({1'b0, idx_q} == (n_q - CntOne));
  assign mismatch   = (chk_val != cur_entry.exp);
  assign any_fail   = fail_q | mismatch;

  // Expectation table: frozen while a run is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHECKS); i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      table_q[cfg_idx] <= {cfg_flag, cfg_reg, cfg_exp};
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    cp_d       = cp_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    run_d      = run_q;
    tcnt_d     = tcnt_q;

    if ((state_q == StWait || state_q == StCheck) && (run_q != '1)) begin
      run_d = run_q + 32'd1;
    end

    case (state_q)
      StIdle, StPass, StFail: begin
        if (start) begin
          n_d        = num_checks;
          idx_d      = '0;
          cp_d       = '0;
          fail_d     = 1'b0;
          timeout_d  = 1'b0;
          fail_idx_d = '0;
          fail_got_d = '0;
          run_d      = '0;
          tcnt_d     = '0;
          state_d    = (num_checks == '0) ? StPass : StWait;
        end
      end

      StWait: begin
        if (flag_hit) begin
          state_d = StCheck;
        end else if (tcnt_q == TimeoutLast) begin
          // A timeout overrides any mismatch already recorded in continue mode.
          state_d    = StFail;
          fail_d     = 1'b1;
          timeout_d  = 1'b1;
          fail_idx_d = idx_q;
          fail_got_d = chk_val;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end

      StCheck: begin
        if (!mismatch) begin
          cp_d = cp_q + CntOne;
        end else if (!fail_q) begin
          fail_d     = 1'b1;
          fail_idx_d = idx_q;
          fail_got_d = chk_val;
        end

        if (mismatch && (STOP_ON_FAIL != 0)) begin
          state_d = StFail;
        end else if (is_last) begin
          state_d = any_fail ? StFail : StPass;
        end else begin
          idx_d = idx_q + IdxOne;
          if (next_entry.flag != cur_entry.flag) begin
            state_d = StWait;
            tcnt_d  = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Status flags are registered from the next state so outputs come straight from flops.
    busy_d = (state_d == StWait) || (state_d == StCheck);
    done_d = (state_d == StPass) || (state_d == StFail);
    pass_d = (state_d == StPass);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      idx_q      <= '0;
      cp_q       <= '0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      run_q      <= '0;
      tcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      cp_q       <= cp_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      run_q      <= run_d;
      tcnt_q     <= tcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign fail_idx      = fail_idx_q;
  assign fail_got      = fail_got_q;
  assign checks_passed = cp_q;
  assign run_cycles    = run_q;

endmodule
